obi_axi_bridge_mo: RTL and testbench
====================================

Name: obi_axi_bridge_mo

Overview:
Single-clock OBI-slave to AXI4-master bridge with up to MaxOutstanding in-flight transactions. It is the successor of the single-outstanding core2axi bridge in front of the serial link. It adds an AXI data width of 32 or 64 with byte-lane steering, in-order OBI responses, and error propagation. It sits between the X-HEEP OBI bus and the serial-link AXI CDC.

Parameters:
AddrWidth, 32, OBI/AXI address width
AxiDataWidth, 32, AXI data width; legal values 32 or 64
IdWidth, 4, AXI ID width; all IDs are driven to 0
MaxOutstanding, 4, maximum in-flight transactions; must be ≥1 and a power of 2

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
obi_req_i / obi_gnt_o  in/out  1  OBI request / grant
obi_addr_i  in  AddrWidth  OBI byte address
obi_we_i  in  1  OBI write enable
obi_be_i  in  4  OBI byte enables
obi_wdata_i  in  32  OBI write data
obi_rvalid_o  out  1  OBI response valid
obi_rdata_o  out  32  OBI read data
obi_err_o  out  1  OBI error flag
aw_valid_o / aw_ready_i  out/in  1  AXI write-address handshake
aw_addr_o  out  AddrWidth  AXI write address
aw_id_o  out  IdWidth  AXI write ID
aw_size_o  out  3  AXI write size
aw_prot_o  out  3  AXI write protection
w_valid_o / w_ready_i / w_last_o  out/in/out  1  AXI write-data handshake and last flag
w_data_o  out  AxiDataWidth  AXI write data
w_strb_o  out  AxiDataWidth/8  AXI write strobes
b_valid_i / b_ready_o  in/out  1  AXI write-response handshake
b_resp_i  in  2  AXI write response
ar_valid_o / ar_ready_i  out/in  1  AXI read-address handshake
ar_addr_o  out  AddrWidth  AXI read address
ar_id_o  out  IdWidth  AXI read ID
ar_size_o  out  3  AXI read size
ar_prot_o  out  3  AXI read protection
r_valid_i / r_ready_o / r_last_i  in/out/in  1  AXI read-data handshake and last flag
r_data_i  in  AxiDataWidth  AXI read data
r_resp_i  in  2  AXI read response

Behaviour:
- Reset values: every *_valid_o = 0, obi_gnt_o = 0, obi_rvalid_o = 0, obi_err_o = 0, obi_rdata_o = 0, outstanding count = 0, direction = READ, lane FIFO empty.
- Grant rule (combinational): obi_gnt_o = obi_req_i && cnt < MaxOutstanding && (cnt == 0 || dir == obi_we_i) && stage_free.
  - stage_free means: AR register empty for a read; AW pending and W pending both clear for a write.
- On a granted write: in the next cycle aw_valid_o = 1 and w_valid_o = 1.
  - aw_addr_o = {addr[AddrWidth-1:2], 2'b00}; size = 3'd2; len = 0; burst INCR; w_last_o = 1; prot = 3'b000.
  - w_data_o is wdata replicated across all lanes; w_strb_o is be shifted to lane L = addr[$clog2(AxiDataWidth/8)-1:2]; L = 0 when AxiDataWidth = 32.
  - AW and W complete independently; each valid drops on its own handshake. Either order and same-cycle completion are all legal.
- On a granted read: in the next cycle ar_valid_o = 1 with the same address/size rules. Lane L is pushed to the lane FIFO (depth MaxOutstanding).
- Transaction mix: writes and reads are never mixed in flight. dir may change only when cnt == 0, which guarantees in-order responses with a single ID.
- b_ready_o and r_ready_o are tied to 1.
- B handshake: registered; obi_rvalid_o = 1 in the next cycle with obi_err_o = b_resp_i[1] and obi_rdata_o = 0.
- R handshake: registered; obi_rvalid_o = 1 in the next cycle with obi_rdata_o = lane (FIFO head) of r_data_i and obi_err_o = r_resp_i[1]. The FIFO pops on the same cycle.
- obi_rvalid_o is a single-cycle pulse per response.
- Outstanding counter cnt:
  - +1 on grant, -1 on B/R handshake; unchanged when both happen in the same cycle.
  - Width $clog2(MaxOutstanding+1).
- Boundary cases:
  - cnt == MaxOutstanding: gnt = 0.
  - A B handshake with dir = READ, or an R handshake with cnt = 0, is a protocol violation. It fires an assertion (non-synthesis) and the counter saturates at 0.
  - aw_ready_i held low: further writes stall; reads are also blocked by the direction rule.
  - Reset mid-transaction: all state clears immediately. In-flight AXI responses arriving after reset deassertion are ignored through the saturation rule.
- Latency: grant to *_valid_o is 1 cycle; AXI response to obi_rvalid_o is 1 cycle.

Optional Feature:
- Macro OBI_AXI_BRIDGE_PERF_EN.
- When defined, adds the following ports:
  - perf_clear_i (in, 1)
  - perf_rd_cnt_o, perf_wr_cnt_o, perf_err_cnt_o (out, 32 each)
- Counter behaviour: the three counters are saturating and count completed reads, completed writes and error responses. Each resets to 0 and clears synchronously on perf_clear_i; clear wins over a same-cycle increment.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package obi_axi_bridge_pkg holds:
  - direction enum {DIR_READ, DIR_WRITE}
  - AXI_SIZE_4B = 3'd2, AXI_BURST_INCR = 2'b01
  - resp_is_err() function (resp[1])
- One sub-module, obi_axi_bridge_lane_fifo: a synchronous FIFO of lane indices, depth MaxOutstanding, with full/empty flags.

Test Plan:
- Write addr 0x1000_0004, be 4'b0011, wdata 0xAABBCCDD, AxiDataWidth = 64 -> AW addr 0x1000_0004, size 2, w_data 0xAABBCCDD_AABBCCDD, w_strb 8'b0011_0000; obi_rvalid_o pulses 1 cycle after B.
- Read addr 0x0000_0008, AxiDataWidth = 64, r_data 0x1111_2222_3333_4444 -> obi_rdata_o 0x3333_4444, err 0.
- MaxOutstanding = 4, 5 back-to-back reads with ar_ready_i = 1 and R withheld -> 4 grants, 5th gnt = 0 until first R; rdata returned in issue order.
- Write then immediate read -> read gnt = 0 until B returns and cnt == 0; read is then granted.
- aw_ready_i delayed 3 cycles after w_ready_i, then b_resp 2'b10 -> single AW and W handshake each; obi_err_o = 1 with rvalid.
- With OBI_AXI_BRIDGE_PERF_EN: 3 reads, 2 writes, 1 SLVERR -> perf_rd_cnt_o = 3, perf_wr_cnt_o = 2, perf_err_cnt_o = 1; perf_clear_i -> all 0 next cycle.

Source files
------------

// File: rtl/obi_axi_bridge_pkg.sv
// Shared types and AXI constants for the OBI-to-AXI4 multi-outstanding bridge.
// No logic: only the direction enum, fixed AXI encodings and a response decoder.
package obi_axi_bridge_pkg;

    typedef enum logic {
        DIR_READ  = 1'b0,
        DIR_WRITE = 1'b1
    } dir_e;

    localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_PROT_NONE  = 3'b000;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/obi_axi_bridge_lane_fifo.sv
// Lane-index FIFO: remembers which 32-bit lane each outstanding read targets.
// Latency: push visible at head the cycle after it is written; pop is same-cycle.
// Backpressure: push ignored when full, pop ignored when empty (caller bounds occupancy).
module obi_axi_bridge_lane_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
        if (pop_ok)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/obi_axi_bridge_mo.sv
// OBI slave to AXI4 master bridge, up to MaxOutstanding same-direction transactions, single ID.
// Latency: grant -> AXI valid 1 cycle; B/R handshake -> obi_rvalid_o 1 cycle.
// Backpressure: OBI grant withheld on full count, direction change or busy AW/W/AR stage.
// Optional perf counters under OBI_AXI_BRIDGE_PERF_EN.
module obi_axi_bridge_mo
    import obi_axi_bridge_pkg::*;
#(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned AxiDataWidth   = 32,
    parameter int unsigned IdWidth        = 4,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      obi_req_i,
    output logic                      obi_gnt_o,
    input  logic [AddrWidth-1:0]      obi_addr_i,
    input  logic                      obi_we_i,
    input  logic [3:0]                obi_be_i,
    input  logic [31:0]               obi_wdata_i,
    output logic                      obi_rvalid_o,
    output logic [31:0]               obi_rdata_o,
    output logic                      obi_err_o,
    output logic                      aw_valid_o,
    input  logic                      aw_ready_i,
    output logic [AddrWidth-1:0]      aw_addr_o,
    output logic [IdWidth-1:0]        aw_id_o,
    output logic [2:0]                aw_size_o,
    output logic [2:0]                aw_prot_o,
    output logic                      w_valid_o,
    input  logic                      w_ready_i,
    output logic                      w_last_o,
    output logic [AxiDataWidth-1:0]   w_data_o,
    output logic [AxiDataWidth/8-1:0] w_strb_o,
    input  logic                      b_valid_i,
    output logic                      b_ready_o,
    input  logic [1:0]                b_resp_i,
    output logic                      ar_valid_o,
    input  logic                      ar_ready_i,
    output logic [AddrWidth-1:0]      ar_addr_o,
    output logic [IdWidth-1:0]        ar_id_o,
    output logic [2:0]                ar_size_o,
    output logic [2:0]                ar_prot_o,
    input  logic                      r_valid_i,
    output logic                      r_ready_o,
    input  logic                      r_last_i,
    input  logic [AxiDataWidth-1:0]   r_data_i,
    input  logic [1:0]                r_resp_i
`ifdef OBI_AXI_BRIDGE_PERF_EN
    ,
    input  logic                      perf_clear_i,
    output logic [31:0]               perf_rd_cnt_o,
    output logic [31:0]               perf_wr_cnt_o,
    output logic [31:0]               perf_err_cnt_o
`endif
);

    localparam int unsigned Lanes = AxiDataWidth / 32;
    localparam int unsigned LaneW = (Lanes > 1) ? $clog2(Lanes) : 1;
    localparam int unsigned StrbW = AxiDataWidth / 8;
    localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);

    logic [CntW-1:0]         cnt_q, cnt_d;
    dir_e                    dir_q, dir_d;
    logic                    ar_vld_q, ar_vld_d, aw_vld_q, aw_vld_d, w_vld_q, w_vld_d;
    logic [AddrWidth-1:0]    ar_addr_q, ar_addr_d, aw_addr_q, aw_addr_d;
    logic [AxiDataWidth-1:0] w_dat_q, w_dat_d;
    logic [StrbW-1:0]        w_strb_q, w_strb_d;
    logic                    rsp_vld_q, rsp_vld_d, rsp_err_q, rsp_err_d;
    logic [31:0]             rsp_dat_q, rsp_dat_d;

    logic                    gnt, stage_free, dir_ok, b_ok, r_ok;
    logic [LaneW-1:0]        req_lane, head_lane;
    logic [AddrWidth-1:0]    word_addr;
    logic [AxiDataWidth-1:0] r_shifted;
    logic                    fifo_full, fifo_empty;
    logic                    unused_bits;

    assign req_lane   = (Lanes > 1) ? obi_addr_i[2 +: LaneW] : '0;
    assign word_addr  = {obi_addr_i[AddrWidth-1:2], 2'b00};
    assign stage_free = obi_we_i ? (!aw_vld_q && !w_vld_q) : !ar_vld_q;
    assign dir_ok     = (cnt_q == '0) || (dir_q == (obi_we_i ? DIR_WRITE : DIR_READ));
    assign gnt        = obi_req_i && (cnt_q < CntW'(MaxOutstanding)) && dir_ok && stage_free;

    // Responses outside a matching in-flight transaction are dropped, keeping cnt_q at 0.
    assign b_ok = b_valid_i && (dir_q == DIR_WRITE) && (cnt_q != '0);
    assign r_ok = r_valid_i && (dir_q == DIR_READ) && (cnt_q != '0);

    assign r_shifted = r_data_i >> {head_lane, 5'd0};

    obi_axi_bridge_lane_fifo #(
        .Depth (MaxOutstanding),
        .Width (LaneW)
    ) u_lane_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (gnt && !obi_we_i),
        .wdata_i (req_lane),
        .pop_i   (r_ok),
        .rdata_o (head_lane),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        ar_vld_d  = ar_vld_q && !ar_ready_i;
        aw_vld_d  = aw_vld_q && !aw_ready_i;
        w_vld_d   = w_vld_q && !w_ready_i;
        ar_addr_d = ar_addr_q;
        aw_addr_d = aw_addr_q;
        w_dat_d   = w_dat_q;
        w_strb_d  = w_strb_q;
        if (gnt) begin
            dir_d = obi_we_i ? DIR_WRITE : DIR_READ;
            if (obi_we_i) begin
                aw_vld_d  = 1'b1;
                w_vld_d   = 1'b1;
                aw_addr_d = word_addr;
                w_dat_d   = {Lanes{obi_wdata_i}};
                w_strb_d  = StrbW'(obi_be_i) << {req_lane, 2'b00};
            end else begin
                ar_vld_d  = 1'b1;
                ar_addr_d = word_addr;
            end
        end
        case ({gnt, b_ok || r_ok})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
        rsp_vld_d = b_ok || r_ok;
        rsp_err_d = b_ok ? resp_is_err(b_resp_i) : (r_ok && resp_is_err(r_resp_i));
        rsp_dat_d = r_ok ? r_shifted[31:0] : 32'h0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            dir_q     <= DIR_READ;
            ar_vld_q  <= 1'b0;
            aw_vld_q  <= 1'b0;
            w_vld_q   <= 1'b0;
            ar_addr_q <= '0;
            aw_addr_q <= '0;
            w_dat_q   <= '0;
            w_strb_q  <= '0;
            rsp_vld_q <= 1'b0;
            rsp_err_q <= 1'b0;
            rsp_dat_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            ar_vld_q  <= ar_vld_d;
            aw_vld_q  <= aw_vld_d;
            w_vld_q   <= w_vld_d;
            ar_addr_q <= ar_addr_d;
            aw_addr_q <= aw_addr_d;
            w_dat_q   <= w_dat_d;
            w_strb_q  <= w_strb_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_err_q <= rsp_err_d;
            rsp_dat_q <= rsp_dat_d;
        end
    end

    assign obi_gnt_o    = gnt;
    assign obi_rvalid_o = rsp_vld_q;
    assign obi_rdata_o  = rsp_dat_q;
    assign obi_err_o    = rsp_err_q;
    assign aw_valid_o   = aw_vld_q;
    assign aw_addr_o    = aw_addr_q;
    assign aw_id_o      = '0;
    assign aw_size_o    = AXI_SIZE_4B;
    assign aw_prot_o    = AXI_PROT_NONE;
    assign w_valid_o    = w_vld_q;
    assign w_last_o     = 1'b1;
    assign w_data_o     = w_dat_q;
    assign w_strb_o     = w_strb_q;
    assign b_ready_o    = 1'b1;
    assign ar_valid_o   = ar_vld_q;
    assign ar_addr_o    = ar_addr_q;
    assign ar_id_o      = '0;
    assign ar_size_o    = AXI_SIZE_4B;
    assign ar_prot_o    = AXI_PROT_NONE;
    assign r_ready_o    = 1'b1;

    assign unused_bits = ^{r_last_i, b_resp_i[0], r_resp_i[0], obi_addr_i[1:0],
                           fifo_full, fifo_empty};

`ifdef OBI_AXI_BRIDGE_PERF_EN
    logic [31:0] perf_rd_q, perf_wr_q, perf_err_q;
    logic        rsp_is_err;

    assign rsp_is_err = (b_ok && resp_is_err(b_resp_i)) || (r_ok && resp_is_err(r_resp_i));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_rd_q  <= '0;
            perf_wr_q  <= '0;
            perf_err_q <= '0;
        end else if (perf_clear_i) begin
            perf_rd_q  <= '0;
            perf_wr_q  <= '0;
            perf_err_q <= '0;
        end else begin
            if (r_ok && perf_rd_q != '1)       perf_rd_q  <= perf_rd_q + 32'd1;
            if (b_ok && perf_wr_q != '1)       perf_wr_q  <= perf_wr_q + 32'd1;
            if (rsp_is_err && perf_err_q != '1) perf_err_q <= perf_err_q + 32'd1;
        end
    end

    assign perf_rd_cnt_o  = perf_rd_q;
    assign perf_wr_cnt_o  = perf_wr_q;
    assign perf_err_cnt_o = perf_err_q;
`endif

    a_no_stray_b: assert property (@(posedge clk_i) disable iff (!rst_ni) !(b_valid_i && !b_ok));
    a_no_stray_r: assert property (@(posedge clk_i) disable iff (!rst_ni) !(r_valid_i && !r_ok));

endmodule

// File: tb/tb_obi_axi_bridge_mo.sv
// Directed bench for obi_axi_bridge_mo at AxiDataWidth=64, MaxOutstanding=4.
// Covers perf counters when OBI_AXI_BRIDGE_PERF_EN is defined.
module tb_obi_axi_bridge_mo;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        obi_req_i, obi_gnt_o, obi_we_i;
    logic [31:0] obi_addr_i, obi_wdata_i, obi_rdata_o;
    logic [3:0]  obi_be_i;
    logic        obi_rvalid_o, obi_err_o;
    logic        aw_valid_o, aw_ready_i, w_valid_o, w_ready_i, w_last_o;
    logic [31:0] aw_addr_o, ar_addr_o;
    logic [3:0]  aw_id_o, ar_id_o;
    logic [2:0]  aw_size_o, aw_prot_o, ar_size_o, ar_prot_o;
    logic [63:0] w_data_o, r_data_i;
    logic [7:0]  w_strb_o;
    logic        b_valid_i, b_ready_o, ar_valid_o, ar_ready_i;
    logic        r_valid_i, r_ready_o, r_last_i;
    logic [1:0]  b_resp_i, r_resp_i;
`ifdef OBI_AXI_BRIDGE_PERF_EN
    logic        perf_clear_i;
    logic [31:0] perf_rd_cnt_o, perf_wr_cnt_o, perf_err_cnt_o;
`endif

    int vectors = 0;
    int miscompares = 0;
    int aw_hs = 0;
    int w_hs = 0;
    int aw_base, w_base;

    obi_axi_bridge_mo #(
        .AddrWidth(32), .AxiDataWidth(64), .IdWidth(4), .MaxOutstanding(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o), .obi_addr_i(obi_addr_i),
        .obi_we_i(obi_we_i), .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i),
        .obi_rvalid_o(obi_rvalid_o), .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
        .aw_id_o(aw_id_o), .aw_size_o(aw_size_o), .aw_prot_o(aw_prot_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_last_o(w_last_o),
        .w_data_o(w_data_o), .w_strb_o(w_strb_o),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
        .ar_id_o(ar_id_o), .ar_size_o(ar_size_o), .ar_prot_o(ar_prot_o),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_last_i(r_last_i),
        .r_data_i(r_data_i), .r_resp_i(r_resp_i)
`ifdef OBI_AXI_BRIDGE_PERF_EN
        , .perf_clear_i(perf_clear_i), .perf_rd_cnt_o(perf_rd_cnt_o),
        .perf_wr_cnt_o(perf_wr_cnt_o), .perf_err_cnt_o(perf_err_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (aw_valid_o && aw_ready_i) aw_hs <= aw_hs + 1;
        if (w_valid_o && w_ready_i)   w_hs  <= w_hs + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0; obi_req_i = 1'b0; obi_we_i = 1'b0; obi_addr_i = '0;
        obi_be_i = '0; obi_wdata_i = '0; aw_ready_i = 1'b0; w_ready_i = 1'b0;
        b_valid_i = 1'b0; b_resp_i = '0; ar_ready_i = 1'b0; r_valid_i = 1'b0;
        r_last_i = 1'b1; r_data_i = '0; r_resp_i = '0;
`ifdef OBI_AXI_BRIDGE_PERF_EN
        perf_clear_i = 1'b0;
`endif
        tick; tick;
        chk("rst_gnt", obi_gnt_o, 0);
        chk("rst_valids", {aw_valid_o, w_valid_o, ar_valid_o}, 0);
        chk("rst_rsp", {obi_rvalid_o, obi_err_o, obi_rdata_o}, 0);
        rst_ni = 1'b1;
        tick;

        // Write to lane 1 of a 64-bit bus
        obi_req_i = 1'b1; obi_we_i = 1'b1; obi_addr_i = 32'h1000_0004;
        obi_be_i = 4'b0011; obi_wdata_i = 32'hAABB_CCDD;
        #1 chk("wr_gnt", obi_gnt_o, 1);
        tick;
        obi_req_i = 1'b0; obi_we_i = 1'b0;
        chk("wr_aw_w_valid", {aw_valid_o, w_valid_o}, 2'b11);
        chk("wr_aw_addr", aw_addr_o, 32'h1000_0004);
        chk("wr_aw_size", aw_size_o, 3'd2);
        chk("wr_ids_prot", {aw_id_o, aw_prot_o}, 0);
        chk("wr_wdata", w_data_o, 64'hAABB_CCDD_AABB_CCDD);
        chk("wr_wstrb", w_strb_o, 8'b0011_0000);
        chk("wr_wlast", w_last_o, 1);
        aw_ready_i = 1'b1; w_ready_i = 1'b1;
        tick;
        chk("wr_valids_drop", {aw_valid_o, w_valid_o}, 0);
        chk("wr_no_early_rvalid", obi_rvalid_o, 0);
        b_valid_i = 1'b1; b_resp_i = 2'b00;
        tick;
        b_valid_i = 1'b0;
        chk("wr_rsp", {obi_rvalid_o, obi_err_o, obi_rdata_o}, {2'b10, 32'h0});
        tick;
        chk("wr_rvalid_pulse", obi_rvalid_o, 0);

        // Read from lane 0
        obi_req_i = 1'b1; obi_we_i = 1'b0; obi_addr_i = 32'h0000_0008;
        #1 chk("rd_gnt", obi_gnt_o, 1);
        tick;
        obi_req_i = 1'b0;
        chk("rd_ar_valid", ar_valid_o, 1);
        chk("rd_ar_addr", ar_addr_o, 32'h0000_0008);
        chk("rd_ar_size_id", {ar_size_o, ar_id_o, ar_prot_o}, {3'd2, 4'd0, 3'd0});
        ar_ready_i = 1'b1;
        tick;
        chk("rd_ar_drop", ar_valid_o, 0);
        r_valid_i = 1'b1; r_data_i = 64'h1111_2222_3333_4444; r_resp_i = 2'b00;
        tick;
        r_valid_i = 1'b0;
        chk("rd_rsp", {obi_rvalid_o, obi_err_o, obi_rdata_o}, {2'b10, 32'h3333_4444});

        // Four reads fill the window; the fifth waits for the first R
        obi_req_i = 1'b1; obi_we_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            obi_addr_i = 32'(i * 4);
            #1 chk($sformatf("mo_gnt%0d", i), obi_gnt_o, 1);
            tick;
            chk($sformatf("mo_ar%0d", i), {ar_valid_o, ar_addr_o}, {1'b1, 32'(i * 4)});
            chk($sformatf("mo_gnt_busy%0d", i), obi_gnt_o, 0);
            tick;
        end
        obi_addr_i = 32'h0000_0010;
        #1 chk("mo_gnt_full", obi_gnt_o, 0);
        tick;
        chk("mo_gnt_full2", obi_gnt_o, 0);
        r_valid_i = 1'b1; r_data_i = {32'hB000_0000, 32'hA000_0000};
        tick;
        r_valid_i = 1'b0;
        chk("mo_rdata0", {obi_rvalid_o, obi_rdata_o}, {1'b1, 32'hA000_0000});
        chk("mo_gnt_after_r", obi_gnt_o, 1);
        tick;
        obi_req_i = 1'b0;
        chk("mo_ar4", {ar_valid_o, ar_addr_o}, {1'b1, 32'h0000_0010});
        tick;
        for (int i = 1; i < 5; i++) begin
            r_valid_i = 1'b1;
            r_data_i = {32'hB000_0000 | 32'(i), 32'hA000_0000 | 32'(i)};
            tick;
            chk($sformatf("mo_rdata%0d", i), {obi_rvalid_o, obi_rdata_o},
                {1'b1, ((i % 2) == 1) ? (32'hB000_0000 | 32'(i)) : (32'hA000_0000 | 32'(i))});
        end
        r_valid_i = 1'b0;
        tick;
        chk("mo_idle", obi_rvalid_o, 0);

        // Write followed immediately by a read: read waits for the B
        obi_req_i = 1'b1; obi_we_i = 1'b1; obi_addr_i = 32'h0000_0020;
        obi_be_i = 4'hF; obi_wdata_i = 32'h5566_7788;
        #1 chk("mix_wr_gnt", obi_gnt_o, 1);
        tick;
        obi_we_i = 1'b0; obi_addr_i = 32'h0000_0024;
        #1 chk("mix_rd_blocked", obi_gnt_o, 0);
        tick;
        chk("mix_rd_blocked2", obi_gnt_o, 0);
        b_valid_i = 1'b1; b_resp_i = 2'b00;
        tick;
        b_valid_i = 1'b0;
        chk("mix_b_rvalid", obi_rvalid_o, 1);
        chk("mix_rd_gnt", obi_gnt_o, 1);
        tick;
        obi_req_i = 1'b0;
        chk("mix_ar", {ar_valid_o, ar_addr_o}, {1'b1, 32'h0000_0024});
        tick;
        r_valid_i = 1'b1; r_data_i = 64'hDEAD_BEEF_0123_4567; r_resp_i = 2'b00;
        tick;
        r_valid_i = 1'b0;
        chk("mix_rdata", {obi_rvalid_o, obi_err_o, obi_rdata_o}, {2'b10, 32'hDEAD_BEEF});

        // AW accepted 3 cycles after W, then SLVERR
        aw_ready_i = 1'b0; w_ready_i = 1'b0;
        obi_req_i = 1'b1; obi_we_i = 1'b1; obi_addr_i = 32'h0000_0030;
        obi_be_i = 4'b1000; obi_wdata_i = 32'h1234_5678;
        #1 chk("err_gnt", obi_gnt_o, 1);
        tick;
        obi_req_i = 1'b0; obi_we_i = 1'b0;
        chk("err_wstrb", w_strb_o, 8'h08);
        chk("err_wdata", w_data_o, 64'h1234_5678_1234_5678);
        aw_base = aw_hs; w_base = w_hs;
        w_ready_i = 1'b1;
        tick;
        w_ready_i = 1'b0;
        chk("err_w_done_aw_pend", {w_valid_o, aw_valid_o}, 2'b01);
        tick; tick;
        chk("err_aw_still", aw_valid_o, 1);
        aw_ready_i = 1'b1;
        tick;
        aw_ready_i = 1'b0;
        chk("err_aw_drop", aw_valid_o, 0);
        chk("err_hs_counts", {aw_hs - aw_base, w_hs - w_base}, {32'd1, 32'd1});
        b_valid_i = 1'b1; b_resp_i = 2'b10;
        tick;
        b_valid_i = 1'b0;
        chk("err_rsp", {obi_rvalid_o, obi_err_o}, 2'b11);
        tick;
        chk("err_pulse", obi_rvalid_o, 0);

`ifdef OBI_AXI_BRIDGE_PERF_EN
        chk("perf_rd", perf_rd_cnt_o, 7);
        chk("perf_wr", perf_wr_cnt_o, 3);
        chk("perf_err", perf_err_cnt_o, 1);
        perf_clear_i = 1'b1;
        tick;
        perf_clear_i = 1'b0;
        chk("perf_clear", {perf_rd_cnt_o, perf_wr_cnt_o}, 0);
        chk("perf_clear_err", perf_err_cnt_o, 0);
`endif

        // Reset while a read is outstanding clears count and direction
        ar_ready_i = 1'b0;
        obi_req_i = 1'b1; obi_we_i = 1'b0; obi_addr_i = 32'h0000_0040;
        #1 chk("rst_mid_gnt", obi_gnt_o, 1);
        tick;
        obi_req_i = 1'b0;
        chk("rst_mid_ar", ar_valid_o, 1);
        #2 rst_ni = 1'b0;
        #1 chk("rst_mid_clear", {ar_valid_o, obi_rvalid_o}, 0);
        tick;
        rst_ni = 1'b1;
        obi_req_i = 1'b1; obi_we_i = 1'b1; obi_addr_i = 32'h0000_0044;
        #1 chk("rst_mid_wr_gnt", obi_gnt_o, 1);
        obi_req_i = 1'b0;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
